// File: rtl/pc_sched_pkg.sv
// Shared defines for the PC scheduler: bus widths, hold codes,
// reset vector and scheduler state encodings.
package pc_sched_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int HOLD_FLAG_BUS = 3;

    localparam logic [HOLD_FLAG_BUS-1:0] HOLD_NONE = 3'd0;
    localparam logic [HOLD_FLAG_BUS-1:0] HOLD_PC   = 3'd1;
    localparam logic [HOLD_FLAG_BUS-1:0] HOLD_IF   = 3'd2;
    localparam logic [HOLD_FLAG_BUS-1:0] HOLD_ID   = 3'd3;

    localparam logic [INST_ADDR_BUS-1:0] CPU_RESET_ADDR = 32'h0;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RST_STR = 2'd1,
        ST_HALT    = 2'd2
    } sched_state_e;

endpackage

// File: rtl/pc_sched_timer.sv
// Saturating bus-stall counter with a sticky timeout flag.
// clr_i wipes both the count and the flag.
module pc_sched_timer #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic busy_i,
    output logic timeout_o
);

    logic [7:0] cnt;
    logic [7:0] cnt_nxt;

    always_comb begin
        cnt_nxt = 8'd0;
        if (busy_i) begin
            cnt_nxt = (cnt == 8'hff) ? cnt : cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 8'd0;
            timeout_o <= 1'b0;
        end else if (clr_i) begin
            cnt       <= 8'd0;
            timeout_o <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (int'(cnt_nxt) >= BUS_TIMEOUT) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_sched.sv
// PC scheduler: arbitrates redirects, stalls, debug halt and
// debug core-reset into registered commands for the PC register.
module pc_sched
    import pc_sched_pkg::*;
#(
    parameter int RST_STRETCH = 4,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_jump_req_i,
    input  logic [INST_ADDR_BUS-1:0] ex_jump_addr_i,
    input  logic                     ex_hold_req_i,
    input  logic                     clint_int_req_i,
    input  logic [INST_ADDR_BUS-1:0] clint_int_addr_i,
    input  logic                     clint_hold_req_i,
    input  logic                     rib_hold_req_i,
    input  logic                     jtag_halt_req_i,
    input  logic                     jtag_reset_req_i,
    output logic                     jump_flag_o,
    output logic [INST_ADDR_BUS-1:0] jump_addr_o,
    output logic [HOLD_FLAG_BUS-1:0] hold_flag_o,
    output logic                     jtag_reset_flag_o,
    output logic                     halted_o,
    output logic                     bus_timeout_o
);

    sched_state_e              state;
    logic [3:0]                str_cnt;
    logic                      pend_vld;
    logic                      pend_int;
    logic [INST_ADDR_BUS-1:0]  pend_addr;
    logic                      jrst_q;

    logic                      rst_edge;
    logic                      redirect;
    logic [INST_ADDR_BUS-1:0]  redir_addr;
    logic [HOLD_FLAG_BUS-1:0]  run_hold;

    always_comb begin
        rst_edge   = jtag_reset_req_i & ~jrst_q;
        redirect   = clint_int_req_i | ex_jump_req_i;
        redir_addr = clint_int_req_i ? clint_int_addr_i
                                     : ex_jump_addr_i;
        run_hold   = HOLD_NONE;
        if (ex_hold_req_i || clint_hold_req_i) begin
            run_hold = HOLD_ID;
        end else if (rib_hold_req_i || pend_vld) begin
            run_hold = HOLD_PC;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ST_RUN;
            str_cnt           <= 4'd0;
            pend_vld          <= 1'b0;
            pend_int          <= 1'b0;
            pend_addr         <= CPU_RESET_ADDR;
            jrst_q            <= 1'b0;
            jump_flag_o       <= 1'b0;
            jump_addr_o       <= CPU_RESET_ADDR;
            hold_flag_o       <= HOLD_NONE;
            jtag_reset_flag_o <= 1'b0;
            halted_o          <= 1'b0;
        end else begin
            jrst_q      <= jtag_reset_req_i;
            jump_flag_o <= 1'b0;
            if (rst_edge) begin
                state             <= ST_RST_STR;
                str_cnt           <= 4'(RST_STRETCH);
                pend_vld          <= 1'b0;
                pend_int          <= 1'b0;
                jtag_reset_flag_o <= 1'b1;
                hold_flag_o       <= HOLD_ID;
                halted_o          <= 1'b0;
            end else if (state == ST_RST_STR && str_cnt > 4'd1) begin
                str_cnt           <= str_cnt - 4'd1;
                jtag_reset_flag_o <= 1'b1;
                hold_flag_o       <= HOLD_ID;
            end else if (state == ST_RST_STR) begin
                // Stretch done; this cycle only settles the new state.
                state             <= jtag_halt_req_i ? ST_HALT : ST_RUN;
                str_cnt           <= 4'd0;
                jtag_reset_flag_o <= 1'b0;
                halted_o          <= jtag_halt_req_i;
                hold_flag_o       <= jtag_halt_req_i ? HOLD_ID : HOLD_NONE;
            end else if (jtag_halt_req_i) begin
                state       <= ST_HALT;
                halted_o    <= 1'b1;
                hold_flag_o <= HOLD_ID;
            end else begin
                state       <= ST_RUN;
                halted_o    <= 1'b0;
                hold_flag_o <= run_hold;
                if (!rib_hold_req_i) begin
                    if (redirect) begin
                        jump_flag_o <= 1'b1;
                        jump_addr_o <= redir_addr;
                    end else if (pend_vld) begin
                        jump_flag_o <= 1'b1;
                        jump_addr_o <= pend_addr;
                    end
                    pend_vld <= 1'b0;
                    pend_int <= 1'b0;
                end else if (clint_int_req_i) begin
                    pend_vld  <= 1'b1;
                    pend_int  <= 1'b1;
                    pend_addr <= clint_int_addr_i;
                end else if (ex_jump_req_i && !(pend_vld && pend_int)) begin
                    pend_vld  <= 1'b1;
                    pend_int  <= 1'b0;
                    pend_addr <= ex_jump_addr_i;
                end
            end
        end
    end

    pc_sched_timer #(
        .BUS_TIMEOUT (BUS_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (rst_edge),
        .busy_i    (rib_hold_req_i),
        .timeout_o (bus_timeout_o)
    );

endmodule

// File: tb/tb_pc_sched.sv
// Bench for pc_sched: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_pc_sched;

    localparam int RS = 4;
    localparam int BT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_jump_req_i = 1'b0;
    logic [31:0] ex_jump_addr_i = 32'h0;
    logic        ex_hold_req_i = 1'b0;
    logic        clint_int_req_i = 1'b0;
    logic [31:0] clint_int_addr_i = 32'h0;
    logic        clint_hold_req_i = 1'b0;
    logic        rib_hold_req_i = 1'b0;
    logic        jtag_halt_req_i = 1'b0;
    logic        jtag_reset_req_i = 1'b0;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic [2:0]  hold_flag_o;
    logic        jtag_reset_flag_o;
    logic        halted_o;
    logic        bus_timeout_o;

    int n_checks = 0;
    int n_err = 0;

    pc_sched #(
        .RST_STRETCH (RS),
        .BUS_TIMEOUT (BT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_jump_req_i     (ex_jump_req_i),
        .ex_jump_addr_i    (ex_jump_addr_i),
        .ex_hold_req_i     (ex_hold_req_i),
        .clint_int_req_i   (clint_int_req_i),
        .clint_int_addr_i  (clint_int_addr_i),
        .clint_hold_req_i  (clint_hold_req_i),
        .rib_hold_req_i    (rib_hold_req_i),
        .jtag_halt_req_i   (jtag_halt_req_i),
        .jtag_reset_req_i  (jtag_reset_req_i),
        .jump_flag_o       (jump_flag_o),
        .jump_addr_o       (jump_addr_o),
        .hold_flag_o       (hold_flag_o),
        .jtag_reset_flag_o (jtag_reset_flag_o),
        .halted_o          (halted_o),
        .bus_timeout_o     (bus_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining-flag-cycle count, pending slot,
    // stall-run length; expected outputs recomputed every edge.
    bit        m_prev, m_edge, m_exit, m_tflag;
    int        m_left, m_tcnt;
    bit        p_vld, p_int;
    bit [31:0] p_addr;
    bit        e_jump, e_flag, e_halt, e_tout;
    bit [31:0] e_addr;
    bit [2:0]  e_hold;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_prev = 0; m_exit = 0; m_tflag = 0;
            m_left = 0; m_tcnt = 0;
            p_vld = 0; p_int = 0; p_addr = 0;
            e_jump = 0; e_flag = 0; e_halt = 0; e_tout = 0;
            e_addr = 32'h0; e_hold = 3'd0;
        end else begin
            m_edge = jtag_reset_req_i && !m_prev;
            m_prev = jtag_reset_req_i;
            if (m_edge) begin
                m_tcnt = 0;
                m_tflag = 0;
            end else begin
                m_tcnt = rib_hold_req_i ? ((m_tcnt < 255) ? m_tcnt + 1 : 255) : 0;
                if (m_tcnt >= BT) m_tflag = 1;
            end
            e_tout = m_tflag;
            e_jump = 0;
            if (m_edge) begin
                m_left = RS;
                m_exit = 0;
                p_vld = 0;
            end
            if (m_left > 0) begin
                e_flag = 1; e_hold = 3; e_halt = 0;
                m_left--;
                m_exit = (m_left == 0);
            end else if (m_exit) begin
                m_exit = 0;
                e_flag = 0;
                e_halt = jtag_halt_req_i;
                e_hold = jtag_halt_req_i ? 3'd3 : 3'd0;
            end else if (jtag_halt_req_i) begin
                e_flag = 0; e_halt = 1; e_hold = 3;
            end else begin
                e_flag = 0; e_halt = 0;
                if (ex_hold_req_i || clint_hold_req_i) e_hold = 3;
                else if (rib_hold_req_i || p_vld) e_hold = 1;
                else e_hold = 0;
                if (!rib_hold_req_i) begin
                    if (clint_int_req_i) begin
                        e_jump = 1; e_addr = clint_int_addr_i;
                    end else if (ex_jump_req_i) begin
                        e_jump = 1; e_addr = ex_jump_addr_i;
                    end else if (p_vld) begin
                        e_jump = 1; e_addr = p_addr;
                    end
                    p_vld = 0;
                end else if (clint_int_req_i) begin
                    p_vld = 1; p_int = 1; p_addr = clint_int_addr_i;
                end else if (ex_jump_req_i && !(p_vld && p_int)) begin
                    p_vld = 1; p_int = 0; p_addr = ex_jump_addr_i;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("jump_flag", {31'b0, jump_flag_o}, {31'b0, e_jump});
        chk("jump_addr", jump_addr_o, e_addr);
        chk("hold_flag", {29'b0, hold_flag_o}, {29'b0, e_hold});
        chk("rst_flag", {31'b0, jtag_reset_flag_o}, {31'b0, e_flag});
        chk("halted", {31'b0, halted_o}, {31'b0, e_halt});
        chk("timeout", {31'b0, bus_timeout_o}, {31'b0, e_tout});
        chk("jump_excl",
            {31'b0, jump_flag_o & (jtag_reset_flag_o | halted_o)}, 32'h0);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst_jump", {31'b0, jump_flag_o}, 32'h0);
        chk("rst_addr", jump_addr_o, 32'h0);
        chk("rst_hold", {29'b0, hold_flag_o}, 32'h0);
        chk("rst_halted", {31'b0, halted_o}, 32'h0);
        rst = 1'b1;
        cyc();

        ex_jump_req_i = 1; ex_jump_addr_i = 32'h100;
        cyc();
        chk("ex_jump", {31'b0, jump_flag_o}, 32'h1);
        chk("ex_addr", jump_addr_o, 32'h100);
        ex_jump_req_i = 0;
        cyc();
        chk("ex_once", {31'b0, jump_flag_o}, 32'h0);

        rib_hold_req_i = 1; ex_jump_req_i = 1; ex_jump_addr_i = 32'h200;
        cyc();
        chk("rib_h1", {29'b0, hold_flag_o}, 32'h1);
        chk("rib_j1", {31'b0, jump_flag_o}, 32'h0);
        ex_jump_req_i = 0; clint_int_req_i = 1; clint_int_addr_i = 32'h80;
        cyc();
        chk("rib_j2", {31'b0, jump_flag_o}, 32'h0);
        clint_int_req_i = 0;
        cyc();
        chk("rib_h3", {29'b0, hold_flag_o}, 32'h1);
        rib_hold_req_i = 0;
        cyc();
        chk("replay", {31'b0, jump_flag_o}, 32'h1);
        chk("replay_addr", jump_addr_o, 32'h80);
        cyc();
        chk("replay_once", {31'b0, jump_flag_o}, 32'h0);

        rib_hold_req_i = 1; ex_jump_req_i = 1; ex_jump_addr_i = 32'h40;
        cyc();
        ex_jump_req_i = 0; rib_hold_req_i = 0; jtag_halt_req_i = 1;
        repeat (3) begin
            cyc();
            chk("halted", {31'b0, halted_o}, 32'h1);
            chk("halt_nojump", {31'b0, jump_flag_o}, 32'h0);
            chk("halt_hold", {29'b0, hold_flag_o}, 32'h3);
        end
        jtag_halt_req_i = 0;
        cyc();
        chk("unhalt_jump", {31'b0, jump_flag_o}, 32'h1);
        chk("unhalt_addr", jump_addr_o, 32'h40);

        rib_hold_req_i = 1;
        for (int i = 1; i <= 300; i++) begin
            cyc();
            if (i == 254) chk("tout_254", {31'b0, bus_timeout_o}, 32'h0);
            if (i == 255) chk("tout_255", {31'b0, bus_timeout_o}, 32'h1);
        end
        rib_hold_req_i = 0;
        repeat (5) cyc();
        chk("tout_sticky", {31'b0, bus_timeout_o}, 32'h1);

        jtag_reset_req_i = 1;
        cyc();
        chk("str_flag", {31'b0, jtag_reset_flag_o}, 32'h1);
        chk("str_hold", {29'b0, hold_flag_o}, 32'h3);
        chk("str_tout", {31'b0, bus_timeout_o}, 32'h0);
        jtag_reset_req_i = 0;
        repeat (3) begin
            cyc();
            chk("str_flag_n", {31'b0, jtag_reset_flag_o}, 32'h1);
        end
        cyc();
        chk("str_end", {31'b0, jtag_reset_flag_o}, 32'h0);

        jtag_reset_req_i = 1;
        cyc();
        jtag_reset_req_i = 0;
        cyc();
        rst = 1'b0;
        #1;
        chk("abort_flag", {31'b0, jtag_reset_flag_o}, 32'h0);
        chk("abort_hold", {29'b0, hold_flag_o}, 32'h0);
        chk("abort_addr", jump_addr_o, 32'h0);
        chk("abort_jump", {31'b0, jump_flag_o}, 32'h0);
        cyc();
        rst = 1'b1;
        repeat (6) begin
            cyc();
            chk("abort_noflag", {31'b0, jtag_reset_flag_o}, 32'h0);
        end

        for (int i = 0; i < 3000; i++) begin
            ex_jump_req_i    = ($urandom % 4) == 0;
            ex_jump_addr_i   = $urandom;
            clint_int_req_i  = ($urandom % 10) == 0;
            clint_int_addr_i = $urandom;
            ex_hold_req_i    = ($urandom % 10) == 0;
            clint_hold_req_i = ($urandom % 20) == 0;
            if (($urandom % 6) == 0) rib_hold_req_i = ~rib_hold_req_i;
            if (($urandom % 40) == 0) jtag_halt_req_i = ~jtag_halt_req_i;
            jtag_reset_req_i = ($urandom % 50) == 0;
            cyc();
            if (($urandom % 500) == 0) begin
                rst = 1'b0;
                cyc();
                rst = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
